// File: rtl/videocard_host_pkg.sv
// Shared encodings for the video card host loader: FSM states and control register map.
package videocard_host_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WRITE     = 3'd1;
    localparam state_t ST_DRAIN     = 3'd2;
    localparam state_t ST_KICK      = 3'd3;
    localparam state_t ST_POLL_REQ  = 3'd4;
    localparam state_t ST_POLL_WAIT = 3'd5;
    localparam state_t ST_FINISH    = 3'd6;

    localparam int unsigned CTRL_START      = 0;
    localparam int unsigned CTRL_STATUS     = 1;
    localparam int unsigned START_VAL       = 1;
    localparam int unsigned STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/videocard_poll_timer.sv
// Saturating count of status polls issued; flags when the poll budget is used up.
module videocard_poll_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    assign limit_o = (count_q == CW'(LIMIT));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !limit_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/videocard_host_loader.sv
// Streams a block of words into video memory, kicks the card via its control port,
// then polls the status register until idle or until the poll budget runs out.
module videocard_host_loader
    import videocard_host_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = WIDTH / 2,
    parameter int POLL_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_sink_reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    word_count,
    input  logic                 src_valid,
    input  logic [WIDTH-1:0]     src_data,
    output logic                 src_ready,
    output logic [ADDR_W-1:0]    address,
    output logic [WIDTH-1:0]     data_out,
    output logic [WIDTH/8-1:0]   byteenable,
    output logic                 write,
    input  logic                 waitrequest,
    output logic                 address_control,
    output logic [WIDTH-1:0]     data_out_control,
    input  logic [WIDTH-1:0]     data_in_control,
    output logic                 write_control,
    output logic                 read_control,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                write_q, write_d;
    logic                timeout_q, timeout_d;

    logic wr_free, accept, status_busy;
    logic poll_clr, poll_inc, poll_limit;
    logic unused_status;

    // A pending write frees the bus once the slave stops stalling it.
    assign wr_free     = !write_q || !waitrequest;
    assign src_ready   = (state_q == ST_WRITE) && (remaining_q != '0) && wr_free;
    assign accept      = src_valid && src_ready;
    assign status_busy = data_in_control[STATUS_BUSY_BIT];
    assign unused_status = ^data_in_control[WIDTH-1:1];

    assign address          = address_q;
    assign data_out         = data_q;
    assign write            = write_q;
    assign byteenable       = '1;
    assign timeout          = timeout_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_FINISH);
    assign write_control    = (state_q == ST_KICK);
    assign read_control     = (state_q == ST_POLL_REQ);
    assign address_control  = (state_q == ST_POLL_REQ) ? 1'(CTRL_STATUS) : 1'(CTRL_START);
    assign data_out_control = (state_q == ST_KICK) ? WIDTH'(START_VAL) : '0;

    videocard_poll_timer #(
        .LIMIT(POLL_LIMIT)
    ) u_poll_timer (
        .clk_i   (clk),
        .reset_i (reset_sink_reset),
        .clr_i   (poll_clr),
        .inc_i   (poll_inc),
        .limit_o (poll_limit)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        address_d   = address_q;
        data_d      = data_q;
        write_d     = write_q;
        timeout_d   = timeout_q;
        poll_clr    = 1'b0;
        poll_inc    = 1'b0;

        if (wr_free) begin
            write_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = word_count;
                    timeout_d   = 1'b0;
                    poll_clr    = 1'b1;
                    state_d     = (word_count == '0) ? ST_KICK : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    address_d   = ptr_q;
                    data_d      = src_data;
                    write_d     = 1'b1;
                    ptr_d       = ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == ADDR_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_free) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                state_d = ST_POLL_REQ;
            end
            ST_POLL_REQ: begin
                poll_inc = 1'b1;
                state_d  = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (!status_busy) begin
                    state_d = ST_FINISH;
                end else if (poll_limit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    state_d = ST_POLL_REQ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            address_q   <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            address_q   <= address_d;
            data_q      <= data_d;
            write_q     <= write_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_videocard_host_loader.sv
// Scoreboard bench: stimulus queues expected writes and job outcomes; a monitor pops and checks.
module tb_videocard_host_loader;

    localparam int WIDTH      = 32;
    localparam int ADDR_W     = 16;
    localparam int POLL_LIMIT = 8;

    logic                clk = 1'b0;
    logic                reset_sink_reset;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   word_count;
    logic                src_valid;
    logic [WIDTH-1:0]    src_data;
    logic                src_ready;
    logic [ADDR_W-1:0]   address;
    logic [WIDTH-1:0]    data_out;
    logic [WIDTH/8-1:0]  byteenable;
    logic                write;
    logic                waitrequest;
    logic                address_control;
    logic [WIDTH-1:0]    data_out_control;
    logic [WIDTH-1:0]    data_in_control;
    logic                write_control;
    logic                read_control;
    logic                busy;
    logic                done;
    logic                timeout;

    always #5 clk = ~clk;

    videocard_host_loader #(
        .WIDTH(WIDTH),
        .ADDR_W(ADDR_W),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk(clk),
        .reset_sink_reset(reset_sink_reset),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_ready(src_ready),
        .address(address),
        .data_out(data_out),
        .byteenable(byteenable),
        .write(write),
        .waitrequest(waitrequest),
        .address_control(address_control),
        .data_out_control(data_out_control),
        .data_in_control(data_in_control),
        .write_control(write_control),
        .read_control(read_control),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    typedef struct packed {
        logic [31:0] writes;
        logic [31:0] reads;
        logic [31:0] kicks;
        logic        tmo;
    } job_t;

    wr_t              exp_q[$];
    job_t             job_q[$];
    logic [WIDTH-1:0] src_q[$];

    int checks = 0;
    int errors = 0;

    // Scenario knobs, written only by the stimulus process.
    int busy_cfg  = 0;
    int stall_on  = -1;
    int stall_len = 0;
    bit rand_wait = 1'b0;

    // Per-job observations, written only by the monitor process.
    int writes_in_job = 0;
    int reads_in_job  = 0;
    int kicks_in_job  = 0;

    // Status register model: reports busy for the first busy_cfg polls of a job.
    assign data_in_control = {{(WIDTH-1){1'b0}}, (reads_in_job <= busy_cfg)};

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Slave/source driver and monitor.
    initial begin
        wr_t               w;
        job_t              j;
        bit                prev_stall;
        logic [ADDR_W-1:0] prev_addr;
        logic [WIDTH-1:0]  prev_data;
        int                stall_cnt;
        prev_stall  = 1'b0;
        prev_addr   = '0;
        prev_data   = '0;
        stall_cnt   = 0;
        waitrequest = 1'b0;
        src_valid   = 1'b0;
        src_data    = '0;
        forever begin
            @(negedge clk);
            if (write && writes_in_job == stall_on && stall_cnt < stall_len) begin
                waitrequest = 1'b1;
                stall_cnt++;
            end else if (rand_wait) begin
                waitrequest = ($urandom_range(0, 3) == 0);
            end else begin
                waitrequest = 1'b0;
            end
            src_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
            src_data  = src_valid ? src_q[0] : $urandom;
            #1;
            if (reset_sink_reset) begin
                exp_q.delete();
                job_q.delete();
                src_q.delete();
                writes_in_job = 0;
                reads_in_job  = 0;
                kicks_in_job  = 0;
                prev_stall    = 1'b0;
                stall_cnt     = 0;
            end else begin
                if (src_valid && src_ready) void'(src_q.pop_front());
                if (prev_stall) begin
                    chk("hold_write", write, 1);
                    chk("hold_addr", address, prev_addr);
                    chk("hold_data", data_out, prev_data);
                end
                if (write && !waitrequest) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        chk("wr_addr", address, w.addr);
                        chk("wr_data", data_out, w.data);
                    end
                    writes_in_job++;
                end
                prev_stall = write && waitrequest;
                prev_addr  = address;
                prev_data  = data_out;
                if (write_control) begin
                    kicks_in_job++;
                    chk("kick_addr", address_control, 0);
                    chk("kick_data", data_out_control, 1);
                    chk("kick_no_mem_write", write, 0);
                end
                if (read_control) begin
                    reads_in_job++;
                    chk("poll_addr", address_control, 1);
                end
                if (done) begin
                    if (job_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        j = job_q.pop_front();
                        chk("job_writes", writes_in_job, j.writes);
                        chk("job_reads", reads_in_job, j.reads);
                        chk("job_kicks", kicks_in_job, j.kicks);
                        chk("job_timeout", timeout, j.tmo);
                    end
                    writes_in_job = 0;
                    reads_in_job  = 0;
                    kicks_in_job  = 0;
                    stall_cnt     = 0;
                end
            end
        end
    end

    task automatic prepare_job(input logic [ADDR_W-1:0] base, input int count, input int busy_polls,
                               input int st_on, input int st_len, input bit rw, input bit seq);
        job_t              j;
        wr_t               w;
        logic [WIDTH-1:0]  d;
        busy_cfg  = busy_polls;
        stall_on  = st_on;
        stall_len = st_len;
        rand_wait = rw;
        for (int i = 0; i < count; i++) begin
            d = seq ? WIDTH'(i + 1) : WIDTH'($urandom);
            src_q.push_back(d);
            w.addr = base + ADDR_W'(i);
            w.data = d;
            exp_q.push_back(w);
        end
        j.writes = 32'(count);
        j.reads  = (busy_polls + 1 < POLL_LIMIT) ? 32'(busy_polls + 1) : 32'(POLL_LIMIT);
        j.kicks  = 32'd1;
        j.tmo    = (busy_polls >= POLL_LIMIT);
        job_q.push_back(j);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input int count);
        @(negedge clk);
        base_addr  = base;
        word_count = ADDR_W'(count);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit exp_tmo);
        int n;
        n = 0;
        #2;
        while (!done && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!done) begin
            $display("FAIL %s: no done pulse within 3000 cycles", name);
            checks++;
            errors++;
        end else begin
            @(negedge clk);
            #2;
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
            chk("timeout_sticky", timeout, exp_tmo);
        end
    endtask

    task automatic run_job(input string name, input logic [ADDR_W-1:0] base, input int count,
                           input int busy_polls, input int st_on, input int st_len,
                           input bit rw, input bit seq);
        prepare_job(base, count, busy_polls, st_on, st_len, rw, seq);
        pulse_start(base, count);
        if (count == 0) begin
            #2;
            chk("kick_latency", write_control, 1);
        end
        wait_done(name, busy_polls >= POLL_LIMIT);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_src_ready"}, src_ready, 0);
        chk({name, "_address"}, address, 0);
        chk({name, "_data_out"}, data_out, 0);
        chk({name, "_write"}, write, 0);
        chk({name, "_address_control"}, address_control, 0);
        chk({name, "_data_out_control"}, data_out_control, 0);
        chk({name, "_write_control"}, write_control, 0);
        chk({name, "_read_control"}, read_control, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int n;
        reset_sink_reset = 1'b1;
        start            = 1'b0;
        base_addr        = '0;
        word_count       = '0;
        repeat (3) @(negedge clk);
        #2;
        check_all_zero("reset");
        chk("byteenable", byteenable, 4'hF);
        reset_sink_reset = 1'b0;

        run_job("basic", 16'h0000, 4, 0, -1, 0, 1'b0, 1'b1);
        run_job("stall_second", 16'h0100, 4, 1, 1, 3, 1'b0, 1'b0);
        run_job("wrap", 16'hFFFE, 4, 0, -1, 0, 1'b0, 1'b0);
        run_job("zero_count", 16'h0040, 0, 0, -1, 0, 1'b0, 1'b0);
        run_job("poll_timeout", 16'h0200, 2, 100, -1, 0, 1'b0, 1'b0);
        run_job("after_timeout", 16'h0300, 1, 7, -1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            run_job("random", ADDR_W'($urandom), $urandom_range(0, 6), $urandom_range(0, 3),
                    -1, 0, 1'b1, 1'b0);
        end

        // Abort a job while its final write is stalled, then restart.
        prepare_job(16'h0500, 2, 0, 1, 100000, 1'b0, 1'b0);
        pulse_start(16'h0500, 2);
        n = 0;
        while (src_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        chk("drain_write_pending", write, 1);
        chk("drain_busy", busy, 1);
        reset_sink_reset = 1'b1;
        @(negedge clk);
        #2;
        check_all_zero("midjob_reset");
        reset_sink_reset = 1'b0;
        stall_on = -1;
        repeat (5) @(negedge clk);
        #2;
        chk("no_resume", busy, 0);

        // A start pulse while busy must not launch a second job.
        prepare_job(16'h0600, 3, 1, -1, 0, 1'b1, 1'b0);
        pulse_start(16'h0600, 3);
        @(negedge clk);
        pulse_start(16'h1234, 5);
        wait_done("busy_start", 1'b0);
        repeat (20) @(negedge clk);
        #2;
        chk("ignored_start_idle", busy, 0);
        chk("exp_writes_drained", exp_q.size(), 0);
        chk("jobs_drained", job_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/videocard_host_loader.md
VIDEOCARD_HOST_LOADER -- requirements
Module: videocard_host_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width.
REQ-002 SHALL have parameter ADDR_W, default WIDTH/2: memory address width.
REQ-003 SHALL have parameter POLL_LIMIT, default 1024: maximum status polls before timeout.
REQ-004 SHALL have ports in this order, with clk and reset first:
- clk  in  1  one clock
- reset_sink_reset  in  1  reset, synchronous, active-high
- start  in  1  job start pulse
- base_addr  in  ADDR_W  first memory word address
- word_count  in  ADDR_W  words to load
- src_valid  in  1  source word valid
- src_data  in  WIDTH  source word
- src_ready  out  1  source word accepted
- address  out  ADDR_W  memory address
- data_out  out  WIDTH  memory write data
- byteenable  out  WIDTH/8  memory byte enables
- write  out  1  memory write strobe
- waitrequest  in  1  memory slave stall
- address_control  out  1  control register select
- data_out_control  out  WIDTH  control write data
- data_in_control  in  WIDTH  control read data
- write_control  out  1  control write strobe
- read_control  out  1  control read strobe
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- timeout  out  1  sticky: last job timed out

Function
REQ-005 SHALL implement the FSM states IDLE, WRITE, DRAIN, KICK, POLL_REQ, POLL_WAIT and FINISH.
REQ-006 SHALL sample start only in IDLE; start while busy SHALL be ignored.
REQ-007 In IDLE with start=1, SHALL latch base_addr and word_count, clear timeout, and enter WRITE on the next cycle, or KICK if word_count=0.
REQ-008 SHALL drive src_ready = (state==WRITE) && (remaining>0) && (!write || !waitrequest).
REQ-009 On an accepted beat (src_valid && src_ready), SHALL register data_out=src_data and address=current pointer, and assert write on the next cycle; the pointer increments modulo 2^ADDR_W, so it wraps 0xFFFF->0x0000.
REQ-010 While write && waitrequest, SHALL hold address, data_out and write stable.
REQ-011 SHALL deassert write after acceptance if no new beat is taken; src_valid=0 is a bubble with no write.
REQ-012 After the last word is accepted, SHALL go to DRAIN and leave DRAIN when the final write sees waitrequest=0.
REQ-013 SHALL hold byteenable at all ones.
REQ-014 KICK SHALL last exactly one cycle, with write_control=1, address_control=0 and data_out_control=1, then go to POLL_REQ.
REQ-015 POLL_REQ SHALL last one cycle, with read_control=1 and address_control=1, then go to POLL_WAIT.
REQ-016 Control read latency is fixed at 1.
REQ-017 POLL_WAIT SHALL sample data_in_control[0]: 0 (idle) leads to FINISH; 1 increments the poll count and returns to POLL_REQ.
REQ-018 When the poll count reaches POLL_LIMIT, POLL_WAIT SHALL set timeout=1 and go to FINISH.
REQ-019 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-020 SHALL drive busy=1 in every state except IDLE.
REQ-021 write and write_control SHALL never be asserted in the same cycle.
REQ-022 SHALL drive read_control=0 outside POLL_REQ.

Reset
REQ-023 When reset_sink_reset=1 at a clk edge, including mid-job, SHALL enter IDLE and clear all outputs to 0, including write, write_control, read_control, address, data_out, data_out_control, src_ready, busy, done and timeout, with the pointer and counters also cleared.
REQ-024 After reset, SHALL need a new start pulse; an aborted job does not resume.

Structure
REQ-025 Package videocard_host_pkg SHALL hold the state enum, the control register indices (CTRL_START=0, CTRL_STATUS=1), the start value 1 and the status busy bit index 0.
REQ-026 SHALL contain one sub-module, videocard_poll_timer: a poll counter with clear, increment and a limit-reached output.

Verification
REQ-027 A bench SHALL cover: base=0, count=4, data 1..4, waitrequest=0 -> writes to addresses 0..3 with data 1..4, then KICK writing 1 to control 0, then polls; status 0 on the first poll -> done pulse; timeout=0.
REQ-028 A bench SHALL cover: waitrequest=1 for 3 cycles on the second word -> address/data held 3 cycles; total writes still 4; no word lost or duplicated.
REQ-029 A bench SHALL cover: base=0xFFFE, count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-030 A bench SHALL cover: count=0 -> no memory writes; KICK follows start in 1 cycle; done after the first idle status.
REQ-031 A bench SHALL cover: POLL_LIMIT=8 with status held at 1 -> exactly 8 read_control pulses, then timeout=1 and a done pulse.
REQ-032 A bench SHALL cover: reset asserted during DRAIN, then start asserted while busy in a new job -> all outputs 0 the cycle after reset; the second start is ignored.
